segasys1_sprrom_ctl: RTL and testbench
======================================

# segasys1_sprrom_ctl

Fetch controller and arbiter for the sprite chip-ROM store. It sits between the sprite line renderer, the ROM download loader and the shared 16-bit external memory port. It serves byte reads for the renderer through a one-word cache, and merges loader byte writes onto the same port with loader priority.

## Interface
Parameters:
- AW, 18, byte address width of the sprite ROM space (word address is AW-1 bits)

Ports:
- VCLKx8  in  1  system clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- SPR_REQ  in  1  one-cycle read request from renderer
- SPR_ADDR  in  AW  byte address, sampled with SPR_REQ
- SPR_BUSY  out  1  high from accepted SPR_REQ until SPR_VALID
- SPR_VALID  out  1  one-cycle pulse, SPR_DATA valid
- SPR_DATA  out  8  read byte, held until next SPR_VALID
- LD_WE  in  1  one-cycle byte write from loader
- LD_ADDR  in  AW  loader byte address
- LD_DATA  in  8  loader byte
- LD_BUSY  out  1  high from accepted LD_WE until write acknowledged
- MEM_REQ  out  1  memory request, level, held until MEM_ACK
- MEM_WE  out  1  1 = write, 0 = read; stable while MEM_REQ
- MEM_ADDR  out  AW-1  word address
- MEM_BE  out  2  byte enables; [0] selects bits 7:0, [1] selects bits 15:8
- MEM_WDATA  out  16  write data, byte replicated on both halves
- MEM_ACK  in  1  one-cycle completion; MEM_RDATA valid in the same cycle
- MEM_RDATA  in  16  read word

## Operation
- Byte order: even byte address maps to bits 7:0 and odd to bits 15:8. Word address is byte address[AW-1:1].
- Pending flags spr_pend and ld_pend are set by SPR_REQ and LD_WE. Address and data are latched at the same time.
- Requests arriving while the matching BUSY output is high are a protocol violation. They are ignored and the pending request is not altered.
- State machine:
  - IDLE: if ld_pend, go to WR and issue a write. Otherwise, if spr_pend and it is a cache hit, return the byte and stay in IDLE. Otherwise, if spr_pend and it is a cache miss, go to RD and issue a read.
  - WR: hold MEM_REQ with MEM_WE=1 and MEM_BE one-hot. On MEM_ACK, clear ld_pend, drop LD_BUSY and return to IDLE. If the written word address equals the cache tag, clear cache valid.
  - RD: hold MEM_REQ with MEM_WE=0 and MEM_BE=2'b11. On MEM_ACK, load the cache (tag and word, valid=1), select the byte, pulse SPR_VALID, clear spr_pend and return to IDLE.
- Loader has strict priority. SPR_REQ and LD_WE in the same cycle: the write completes first, then the read is evaluated against the updated cache state.
- A read whose word address matches the tag of an invalid cache line is a miss.
- Cache tag is AW-1 bits. No other state.

## Timing
- Reset values: SPR_BUSY, SPR_VALID, LD_BUSY, MEM_REQ and MEM_WE are 0. SPR_DATA, MEM_ADDR, MEM_BE and MEM_WDATA are 0. Cache valid and both pend flags are 0. State is IDLE.
- BUSY rises the cycle after the accepting request edge.
- Cache hit: SPR_REQ at cycle N gives SPR_VALID at N+1 (1-cycle latency).
- Miss or write: MEM_REQ rises at N+1. MEM_ACK at cycle M gives SPR_VALID or LD_BUSY drop at M+1, and MEM_REQ low at M+1.
- Back-to-back memory transactions need at least one IDLE cycle (MEM_REQ low for at least 1 cycle).
- MEM_ACK while MEM_REQ is low is ignored.
- Reset asserted mid-transaction: MEM_REQ drops asynchronously, and the outstanding access is abandoned without a retry.

## Configuration
- SPRROM_CACHE_EN defined: one-word cache as described.
- SPRROM_CACHE_EN undefined: cache logic removed and every read goes to RD. Minimum read latency becomes MEM_ACK+1, and loader writes perform no tag compare.

## Structure
- Shared package segasys1_pkg holds the state enum (IDLE, RD, WR), the AW default and the byte-lane select helper constants.
- No sub-module is required.
- The cache (tag, word and valid) is kept inline as registers, because it is a single entry.

## Test plan
- Reset, then SPR_REQ addr 0x00010 with MEM_ACK 3 cycles after MEM_REQ and MEM_RDATA 0xBEEF -> MEM_ADDR 0x00008 with BE 2'b11, then SPR_VALID with SPR_DATA 0xEF.
- Next SPR_REQ addr 0x00011 -> no MEM_REQ; SPR_VALID next cycle with SPR_DATA 0xBE.
- LD_WE addr 0x00011 data 0x5A, then SPR_REQ 0x00010 -> write with BE 2'b10 and WDATA 0x5A5A; cache invalidated; the read reissues MEM_REQ.
- SPR_REQ 0x00020 and LD_WE 0x00040 in the same cycle -> the write transaction precedes the read; the two MEM_REQ pulses are separated by at least 1 low cycle.
- RESET_N low while MEM_REQ is high -> MEM_REQ, SPR_BUSY and LD_BUSY are 0 immediately; after release, a read of a previously cached address misses.
- Build without SPRROM_CACHE_EN, repeating the first two reads -> both reads issue MEM_REQ.

Source files
------------

// File: rtl/segasys1_pkg.sv
// Shared definitions for the Sega System 1 sprite ROM fetch path:
// controller states, default address width and byte-lane helpers.
package segasys1_pkg;

  // Default byte address width of the sprite ROM space.
  localparam int unsigned SprAw = 18;

  // Byte-lane enables on the 16-bit memory port.
  localparam logic [1:0] BeLo   = 2'b01;
  localparam logic [1:0] BeHi   = 2'b10;
  localparam logic [1:0] BeWord = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr
  } spr_state_e;

  // Even byte address lives in bits 7:0, odd in bits 15:8.
  function automatic logic [7:0] lane_byte(logic [15:0] word, logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [1:0] lane_be(logic hi);
    return hi ? BeHi : BeLo;
  endfunction

endpackage

// File: rtl/segasys1_sprrom_ctl.sv
// Sprite chip-ROM fetch controller and arbiter. Renderer byte reads are served
// through a one-word cache; loader byte writes share the 16-bit memory port and
// win arbitration. Define SPRROM_CACHE_EN to build the cache; without it every
// read goes to memory and writes skip the tag compare.
module segasys1_sprrom_ctl
  import segasys1_pkg::*;
#(
  parameter int unsigned AW = SprAw
) (
  input  logic          VCLKx8,
  input  logic          RESET_N,
  input  logic          SPR_REQ,
  input  logic [AW-1:0] SPR_ADDR,
  output logic          SPR_BUSY,
  output logic          SPR_VALID,
  output logic [7:0]    SPR_DATA,
  input  logic          LD_WE,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [7:0]    LD_DATA,
  output logic          LD_BUSY,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-2:0] MEM_ADDR,
  output logic [1:0]    MEM_BE,
  output logic [15:0]   MEM_WDATA,
  input  logic          MEM_ACK,
  input  logic [15:0]   MEM_RDATA
);

  spr_state_e state_q, state_d;

  logic          spr_pend_q, spr_pend_d;
  logic [AW-1:0] spr_addr_q, spr_addr_d;
  logic          ld_pend_q, ld_pend_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]    ld_data_q, ld_data_d;
  logic          spr_busy_q, spr_busy_d;
  logic          spr_valid_q, spr_valid_d;
  logic [7:0]    spr_data_q, spr_data_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-2:0] mem_addr_q, mem_addr_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;

  // Requests are only accepted while the matching BUSY is low; the accepting
  // edge already sees them, so a hit answers with one cycle of latency.
  logic          spr_acc, ld_acc, mem_ack;
  logic          spr_pend_eff, ld_pend_eff;
  logic [AW-1:0] spr_addr_eff, ld_addr_eff;
  logic [7:0]    ld_data_eff;
  logic          cache_hit;
  logic [7:0]    cache_byte;

  assign spr_acc      = SPR_REQ & ~spr_busy_q;
  assign ld_acc       = LD_WE & ~ld_pend_q;
  assign mem_ack      = MEM_ACK & mem_req_q;
  assign spr_pend_eff = spr_pend_q | spr_acc;
  assign spr_addr_eff = spr_acc ? SPR_ADDR : spr_addr_q;
  assign ld_pend_eff  = ld_pend_q | ld_acc;
  assign ld_addr_eff  = ld_acc ? LD_ADDR : ld_addr_q;
  assign ld_data_eff  = ld_acc ? LD_DATA : ld_data_q;

`ifdef SPRROM_CACHE_EN
  logic [AW-2:0] tag_q, tag_d;
  logic [15:0]   word_q, word_d;
  logic          cval_q, cval_d;

  assign cache_hit  = cval_q && (tag_q == spr_addr_eff[AW-1:1]);
  assign cache_byte = lane_byte(word_q, spr_addr_eff[0]);

  // Fill on read completion; a write to the cached word invalidates it.
  always_comb begin
    tag_d  = tag_q;
    word_d = word_q;
    cval_d = cval_q;
    if (state_q == StRd && mem_ack) begin
      tag_d  = mem_addr_q;
      word_d = MEM_RDATA;
      cval_d = 1'b1;
    end else if (state_q == StWr && mem_ack && mem_addr_q == tag_q) begin
      cval_d = 1'b0;
    end
  end

  // Cache entry registers.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      tag_q  <= '0;
      word_q <= '0;
      cval_q <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      word_q <= word_d;
      cval_q <= cval_d;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_byte = 8'h00;
`endif

  // State register.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next state: loader first, then a read that misses the cache.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ld_pend_eff)                    state_d = StWr;
        else if (spr_pend_eff && !cache_hit) state_d = StRd;
      end
      StWr:    if (mem_ack) state_d = StIdle;
      StRd:    if (mem_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and request bookkeeping; all outputs leave through registers.
  always_comb begin
    spr_pend_d  = spr_pend_eff;
    spr_addr_d  = spr_addr_eff;
    ld_pend_d   = ld_pend_eff;
    ld_addr_d   = ld_addr_eff;
    ld_data_d   = ld_data_eff;
    spr_valid_d = 1'b0;
    spr_data_d  = spr_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (ld_pend_eff) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ld_addr_eff[AW-1:1];
          mem_be_d    = lane_be(ld_addr_eff[0]);
          mem_wdata_d = {ld_data_eff, ld_data_eff};
        end else if (spr_pend_eff) begin
          if (cache_hit) begin
            spr_valid_d = 1'b1;
            spr_data_d  = cache_byte;
            spr_pend_d  = 1'b0;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = spr_addr_eff[AW-1:1];
            mem_be_d   = BeWord;
          end
        end
      end
      StWr: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ld_pend_d = 1'b0;
        end
      end
      StRd: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          spr_valid_d = 1'b1;
          spr_data_d  = lane_byte(MEM_RDATA, spr_addr_q[0]);
          spr_pend_d  = 1'b0;
        end
      end
      default: ;
    endcase
    // Busy covers the answering cycle so a request there is not lost.
    spr_busy_d = spr_pend_d | spr_valid_d;
  end

  // Datapath and output registers.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      spr_pend_q  <= 1'b0;
      spr_addr_q  <= '0;
      ld_pend_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      spr_busy_q  <= 1'b0;
      spr_valid_q <= 1'b0;
      spr_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      spr_pend_q  <= spr_pend_d;
      spr_addr_q  <= spr_addr_d;
      ld_pend_q   <= ld_pend_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      spr_busy_q  <= spr_busy_d;
      spr_valid_q <= spr_valid_d;
      spr_data_q  <= spr_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign SPR_BUSY  = spr_busy_q;
  assign SPR_VALID = spr_valid_q;
  assign SPR_DATA  = spr_data_q;
  assign LD_BUSY   = ld_pend_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_segasys1_sprrom_ctl.sv
// Testbench for segasys1_sprrom_ctl. Expectations adapt to SPRROM_CACHE_EN.
module tb_segasys1_sprrom_ctl;

  localparam int unsigned AW     = 18;
  localparam int          AckDly = 3;

  logic          VCLKx8 = 1'b0;
  logic          RESET_N = 1'b0;
  logic          SPR_REQ = 1'b0;
  logic [AW-1:0] SPR_ADDR = '0;
  logic          SPR_BUSY, SPR_VALID;
  logic [7:0]    SPR_DATA;
  logic          LD_WE = 1'b0;
  logic [AW-1:0] LD_ADDR = '0;
  logic [7:0]    LD_DATA = '0;
  logic          LD_BUSY;
  logic          MEM_REQ, MEM_WE;
  logic [AW-2:0] MEM_ADDR;
  logic [1:0]    MEM_BE;
  logic [15:0]   MEM_WDATA;
  logic          MEM_ACK = 1'b0;
  logic [15:0]   MEM_RDATA = '0;

  segasys1_sprrom_ctl #(.AW(AW)) dut (
    .VCLKx8(VCLKx8), .RESET_N(RESET_N),
    .SPR_REQ(SPR_REQ), .SPR_ADDR(SPR_ADDR), .SPR_BUSY(SPR_BUSY),
    .SPR_VALID(SPR_VALID), .SPR_DATA(SPR_DATA),
    .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_BUSY(LD_BUSY),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  always #5 VCLKx8 = ~VCLKx8;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
  } txn_t;

  int n_cmp = 0;
  int n_err = 0;

  txn_t        exp_txn[$];   // memory transactions the port must show, in order
  logic [17:0] exp_rd[$];    // byte addresses of outstanding renderer reads
  logic [15:0] mem [int];    // words written so far; others hold init_word
  int          stray_req = 0;
  int          stray_done = 0;

  function automatic logic [15:0] init_word(int i);
    logic [7:0] lo;
    lo = 8'(i);
    if (i == 8) return 16'hBEEF;
    return {lo ^ 8'hA0, lo};
  endfunction

  function automatic logic [15:0] rd_word(int i);
    return mem.exists(i) ? mem[i] : init_word(i);
  endfunction

  function automatic logic [7:0] model_byte(logic [17:0] a);
    logic [15:0] w;
    w = rd_word(int'(a[17:1]));
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory responder: acks AckDly negedges into a request, applies writes.
  int cnt = 0;
  always @(negedge VCLKx8) begin
    if (!RESET_N) begin
      MEM_ACK = 1'b0;
      cnt = 0;
    end else if (MEM_ACK) begin
      MEM_ACK = 1'b0;
      cnt = 0;
    end else if (MEM_REQ) begin
      cnt++;
      if (cnt >= AckDly) begin
        MEM_ACK = 1'b1;
        if (MEM_WE) begin
          logic [15:0] w;
          w = rd_word(int'(MEM_ADDR));
          if (MEM_BE[0]) w[7:0] = MEM_WDATA[7:0];
          if (MEM_BE[1]) w[15:8] = MEM_WDATA[15:8];
          mem[int'(MEM_ADDR)] = w;
        end else begin
          MEM_RDATA = rd_word(int'(MEM_ADDR));
        end
      end
    end else if (stray_req != stray_done) begin
      MEM_ACK = 1'b1;
      MEM_RDATA = 16'hDEAD;
      stray_done++;
    end
  end

  // Per-cycle compare against the model.
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  txn_t        cur;
  always @(negedge VCLKx8) begin
    if (!RESET_N) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
      exp_txn.delete();
      exp_rd.delete();
    end else begin
      if (prev_req && prev_ack) chk("gap_after_ack", 32'(MEM_REQ), 32'd0);
      if (MEM_REQ && !prev_req) begin
        if (exp_txn.size() == 0) begin
          chk("unexpected_mem_req", 32'(MEM_ADDR), 32'hFFFF_FFFF);
        end else begin
          txn_t e;
          e = exp_txn.pop_front();
          chk("mem_we", 32'(MEM_WE), 32'(e.we));
          chk("mem_addr", 32'(MEM_ADDR), 32'(e.addr));
          chk("mem_be", 32'(MEM_BE), 32'(e.be));
          if (e.we) chk("mem_wdata", 32'(MEM_WDATA), 32'(e.wd));
        end
        cur = '{we: MEM_WE, addr: MEM_ADDR, be: MEM_BE, wd: MEM_WDATA};
      end else if (MEM_REQ) begin
        chk("mem_stable",
            32'({MEM_WE, MEM_ADDR, MEM_BE} ^ {cur.we, cur.addr, cur.be}), 32'd0);
      end
      if (SPR_VALID) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_valid", 32'(SPR_DATA), 32'hFFFF_FFFF);
        end else begin
          logic [17:0] a;
          a = exp_rd.pop_front();
          chk("spr_data", 32'(SPR_DATA), 32'(model_byte(a)));
        end
      end
      prev_req = MEM_REQ;
      prev_ack = MEM_ACK;
    end
  end

  task automatic push_rd_txn(input logic [17:0] a);
    exp_txn.push_back('{we: 1'b0, addr: a[17:1], be: 2'b11, wd: 16'h0});
  endtask

  task automatic spr_req(input logic [17:0] a);
    @(posedge VCLKx8); #1;
    exp_rd.push_back(a);
    SPR_REQ = 1'b1; SPR_ADDR = a;
    @(posedge VCLKx8); #1;
    SPR_REQ = 1'b0;
  endtask

  task automatic ld_we(input logic [17:0] a, input logic [7:0] d);
    @(posedge VCLKx8); #1;
    LD_WE = 1'b1; LD_ADDR = a; LD_DATA = d;
    @(posedge VCLKx8); #1;
    LD_WE = 1'b0;
  endtask

  // Negedges until SPR_VALID (bounded); 1 means the cycle right after the request.
  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge VCLKx8);
      lat++;
    end while (!SPR_VALID && lat < 60);
    if (!SPR_VALID) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    do begin
      @(negedge VCLKx8);
      n++;
    end while ((SPR_BUSY || LD_BUSY || MEM_REQ) && n < 60);
    chk({name, "_quiet"}, 32'({SPR_BUSY, LD_BUSY, MEM_REQ}), 32'd0);
    chk({name, "_txn_left"}, 32'(exp_txn.size()), 32'd0);
    chk({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctl"}, 32'({SPR_BUSY, SPR_VALID, LD_BUSY, MEM_REQ, MEM_WE}), 32'd0);
    chk({name, "_data"}, 32'({SPR_DATA, MEM_BE}), 32'd0);
    chk({name, "_mem"}, 32'(MEM_ADDR) | 32'(MEM_WDATA), 32'd0);
  endtask

  int lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset_outputs("reset");
    @(posedge VCLKx8); #1;
    RESET_N = 1'b1;

    // First read misses: word 8 = 0xBEEF, even byte.
    push_rd_txn(18'h00010);
    spr_req(18'h00010);
    @(negedge VCLKx8);
    chk("spr_busy_rise", 32'(SPR_BUSY), 32'd1);
    wait_valid("rd1", lat);
    chk("rd1_data", 32'(SPR_DATA), 32'hEF);
    wait_quiet("rd1");

    // Odd byte of the same word: cache hit in one cycle.
`ifndef SPRROM_CACHE_EN
    push_rd_txn(18'h00011);
`endif
    spr_req(18'h00011);
    wait_valid("rd2", lat);
`ifdef SPRROM_CACHE_EN
    chk("rd2_hit_latency", 32'(lat), 32'd1);
`else
    chk("rd2_miss_latency", 32'(lat > AckDly), 32'd1);
`endif
    chk("rd2_data", 32'(SPR_DATA), 32'hBE);
    wait_quiet("rd2");

    // Write the odd byte of the cached word, then reread: must go to memory.
    exp_txn.push_back('{we: 1'b1, addr: 17'h8, be: 2'b10, wd: 16'h5A5A});
    push_rd_txn(18'h00010);
    ld_we(18'h00011, 8'h5A);
    @(negedge VCLKx8);
    chk("ld_busy_rise", 32'(LD_BUSY), 32'd1);
    spr_req(18'h00010);
    wait_valid("rd3", lat);
    chk("rd3_data", 32'(SPR_DATA), 32'hEF);
    chk("ld_busy_done", 32'(LD_BUSY), 32'd0);
    wait_quiet("rd3");
`ifndef SPRROM_CACHE_EN
    push_rd_txn(18'h00011);
`endif
    spr_req(18'h00011);
    wait_valid("rd4", lat);
    chk("rd4_data", 32'(SPR_DATA), 32'h5A);
    wait_quiet("rd4");

    // Same-cycle read and write: write goes first.
    exp_txn.push_back('{we: 1'b1, addr: 17'h20, be: 2'b01, wd: 16'h7777});
    push_rd_txn(18'h00020);
    @(posedge VCLKx8); #1;
    exp_rd.push_back(18'h00020);
    SPR_REQ = 1'b1; SPR_ADDR = 18'h00020;
    LD_WE = 1'b1; LD_ADDR = 18'h00040; LD_DATA = 8'h77;
    @(posedge VCLKx8); #1;
    SPR_REQ = 1'b0; LD_WE = 1'b0;
    wait_valid("rd5", lat);
    chk("rd5_data", 32'(SPR_DATA), 32'h10);
    wait_quiet("rd5");

    // Stray ack while idle must do nothing.
    stray_req++;
    repeat (4) @(negedge VCLKx8);
    chk("stray_idle", 32'({SPR_VALID, SPR_BUSY, MEM_REQ}), 32'd0);

    // Word 0x20 after the write: high byte 0x80, low byte 0x77.
    push_rd_txn(18'h00041);
    spr_req(18'h00041);
    wait_valid("rd6", lat);
    chk("rd6_data", 32'(SPR_DATA), 32'h80);
    wait_quiet("rd6");
`ifndef SPRROM_CACHE_EN
    push_rd_txn(18'h00040);
`endif
    spr_req(18'h00040);
    wait_valid("rd7", lat);
    chk("rd7_data", 32'(SPR_DATA), 32'h77);
    wait_quiet("rd7");

    // Reset in the middle of a read; the access is abandoned.
    push_rd_txn(18'h00100);
    spr_req(18'h00100);
    lat = 0;
    do begin
      @(negedge VCLKx8);
      lat++;
    end while (!MEM_REQ && lat < 20);
    chk("rst_req_seen", 32'(MEM_REQ), 32'd1);
    @(posedge VCLKx8); #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_async_drop", 32'({MEM_REQ, SPR_BUSY, LD_BUSY}), 32'd0);
    chk_reset_outputs("rst_mid");
    repeat (2) @(negedge VCLKx8);
    @(posedge VCLKx8); #1;
    RESET_N = 1'b1;

    // Previously cached word now misses.
    push_rd_txn(18'h00040);
    spr_req(18'h00040);
    wait_valid("rd8", lat);
    chk("rd8_data", 32'(SPR_DATA), 32'h77);
    wait_quiet("rd8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
